// File: rtl/sequence_detector.sv
// Moore run-length detector: z is high while the last RUN_LEN samples of w are all equal.
// z is registered and changes one edge after the sample that completes or breaks a run.
module sequence_detector #(
  parameter int RUN_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic w,
  output logic z
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    TRACK = 2'b01
  } state_t;

  localparam logic [3:0] RUN_MAX = 4'(RUN_LEN);

  state_t     state_q;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic       last_q;
  logic       z_q;

  // IDLE never matches a prior value, so the first sample after reset always starts at 1.
  always_comb begin
    cnt_d = 4'd1;
    if (state_q == TRACK && w == last_q && cnt_q != 4'd0) begin
      cnt_d = (cnt_q >= RUN_MAX) ? RUN_MAX : cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      last_q  <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, TRACK: begin
          state_q <= TRACK;
          cnt_q   <= cnt_d;
          last_q  <= w;
          z_q     <= (cnt_d == RUN_MAX);
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 4'd0;
          last_q  <= 1'b0;
          z_q     <= 1'b0;
        end
      endcase
    end
  end

  assign z = z_q;

endmodule

// File: tb/tb_sequence_detector.sv
// Bench for sequence_detector: constant vector table plus a history-window reference model.
module tb_sequence_detector;

  localparam int RUN_LEN = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic w = 1'b0;
  logic z;

  sequence_detector #(.RUN_LEN(RUN_LEN)) dut (
    .clk  (clk),
    .reset(reset),
    .w    (w),
    .z    (z)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic w;
    logic z;
  } vec_t;

  vec_t vecs[$];
  logic exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   z_rises  = 0;
  logic prev_z   = 1'b0;

  // Reference: sliding window of the most recent samples since reset.
  logic hist[RUN_LEN];
  int   nvalid = 0;

  function automatic logic model_step(input logic r, input logic wi);
    logic all_eq;
    if (r) begin
      nvalid = 0;
      return 1'b0;
    end
    for (int i = RUN_LEN - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = wi;
    if (nvalid < RUN_LEN) nvalid++;
    all_eq = 1'b1;
    for (int i = 1; i < RUN_LEN; i++) if (hist[i] != hist[0]) all_eq = 1'b0;
    return (nvalid == RUN_LEN) && all_eq;
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: z=%b expected %b", name, act, exp);
  endtask

  // Drive one edge, push expectation, pop and compare after the edge.
  task automatic apply(input string name, input logic r, input logic wi, input logic ez);
    logic e;
    @(negedge clk);
    reset = r;
    w     = wi;
    exp_q.push_back(ez);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: scoreboard empty z=%b expected an entry", name, z);
    end else begin
      e = exp_q.pop_front();
      check(name, z, e);
    end
    if (z === 1'b1 && prev_z !== 1'b1) z_rises++;
    prev_z = z;
  endtask

  task automatic add(input logic r, input logic wi, input logic ez);
    vec_t v;
    v.rst = r; v.w = wi; v.z = ez;
    vecs.push_back(v);
  endtask

  task automatic model_apply(input string name, input logic r, input logic wi);
    apply(name, r, wi, model_step(r, wi));
  endtask

  initial begin
    logic pat[6];
    // reset held two edges with w toggling, then first sample 1
    add(1, 0, 0); add(1, 1, 0); add(0, 1, 0);
    // basic: 111000
    add(1, 0, 0);
    add(0, 1, 0); add(0, 1, 0); add(0, 1, 1);
    add(0, 0, 0); add(0, 0, 0); add(0, 0, 1);
    // long runs: 1x6 then 0x5
    add(1, 1, 0);
    add(0, 1, 0); add(0, 1, 0); add(0, 1, 1); add(0, 1, 1); add(0, 1, 1); add(0, 1, 1);
    add(0, 0, 0); add(0, 0, 0); add(0, 0, 1); add(0, 0, 1); add(0, 0, 1);
    // near-misses
    add(1, 0, 0);
    add(0, 1, 0); add(0, 1, 0); add(0, 0, 0); add(0, 1, 0); add(0, 1, 0);
    add(0, 0, 0); add(0, 0, 0); add(0, 1, 0); add(0, 0, 0);
    // mid-run reset, and reset does not count as a prior 0
    add(1, 1, 0);
    add(0, 0, 0); add(0, 0, 0); add(0, 0, 1);
    add(1, 0, 0);
    add(0, 0, 0); add(0, 0, 0); add(0, 0, 1);
    // reset on a 1-run while z=1
    add(0, 1, 0); add(0, 1, 0); add(0, 1, 1); add(1, 1, 0); add(0, 1, 0);

    #1;
    check("initial_reset_z", z === 1'b1 ? 1'b1 : 1'b0, 1'b0);
    for (int i = 0; i < vecs.size(); i++)
      apply($sformatf("vec%0d", i), vecs[i].rst, vecs[i].w, vecs[i].z);

    // repeated 111000 x10 then 1,0
    pat[0] = 1; pat[1] = 1; pat[2] = 1; pat[3] = 0; pat[4] = 0; pat[5] = 0;
    model_apply("rep_reset", 1, 0);
    z_rises = 0;
    prev_z  = 1'b0;
    for (int r = 0; r < 10; r++)
      for (int k = 0; k < 6; k++)
        model_apply($sformatf("rep%0d_%0d", r, k), 0, pat[k]);
    model_apply("rep_tail1", 0, 1);
    model_apply("rep_tail0", 0, 0);
    n_checks++;
    if (z_rises == 20) n_pass++;
    else $display("FAIL rep_pulse_count: got %0d pulses expected 20", z_rises);

    // random stream with occasional resets
    model_apply("rnd_reset", 1, 0);
    for (int i = 0; i < 300; i++) begin
      logic rr, ww;
      rr = ($urandom_range(0, 39) == 0);
      ww = ($urandom_range(0, 3) != 0) ? w : ~w;
      model_apply($sformatf("rnd%0d", i), rr, ww);
    end

    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
